// File: rtl/gmem_rd_arbiter.sv
// ---------------------------------------------------------------------------
// gmem_rd_arbiter
//
// Purpose:
//    Shares one read port of global memory between a high-priority video port
//    (port 0) and a general-purpose port (port 1). Exactly one burst is
//    outstanding at a time. Port 0 normally wins, but after MAX_CONSEC
//    back-to-back port-0 grants taken while port 1 was waiting, port 1 is
//    served once so it cannot be starved.
//
// Ports:
//    sys_clock            system clock, rising edge
//    async_reset          asynchronous, active-low reset
//    i_req0 / i_req1      level request per port, held until o_busyN is seen
//    i_addr0 / i_addr1    byte start address of the requested burst
//    i_len0 / i_len1      burst length in bytes
//    o_busy0 / o_busy1    port's transfer accepted and in progress
//    o_data0 / o_data1    read data to port
//    o_valid0 / o_valid1  read beat valid to port
//    i_ready0 / i_ready1  port accepts beat
//    o_maddr / o_mlen     registered memory read address / length in bytes
//    o_mreq               registered memory request
//    i_mbusy              memory accepted the request / burst in progress
//    i_mdata / i_mvalid   memory read beat data / valid
//    o_mready             beat accept to memory
//    o_grant              index of the currently / last granted port
// ---------------------------------------------------------------------------
module gmem_rd_arbiter #(
   parameter int MAX_CONSEC = 4
) (
   input  logic        sys_clock,
   input  logic        async_reset,
   input  logic        i_req0,
   input  logic        i_req1,
   input  logic [31:0] i_addr0,
   input  logic [31:0] i_addr1,
   input  logic [31:0] i_len0,
   input  logic [31:0] i_len1,
   output logic        o_busy0,
   output logic        o_busy1,
   output logic [63:0] o_data0,
   output logic [63:0] o_data1,
   output logic        o_valid0,
   output logic        o_valid1,
   input  logic        i_ready0,
   input  logic        i_ready1,
   output logic [31:0] o_maddr,
   output logic [31:0] o_mlen,
   output logic        o_mreq,
   input  logic        i_mbusy,
   input  logic [63:0] i_mdata,
   input  logic        i_mvalid,
   output logic        o_mready,
   output logic        o_grant
);

   localparam int CW = $clog2(MAX_CONSEC + 1);
   localparam logic [CW-1:0] MAXC = CW'(MAX_CONSEC);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_XFER  = 2'd2;

   logic [1:0]    r_state;
   logic [31:0]   r_maddr;
   logic [31:0]   r_mlen;
   logic          r_mreq;
   logic          r_grant;
   logic [28:0]   r_beats;
   logic [CW-1:0] r_consec;

   logic          w_consecFull;
   logic          w_win0;
   logic          w_win1;
   logic          w_anyWin;
   logic [31:0]   w_selAddr;
   logic [31:0]   w_selLen;
   logic [28:0]   w_selBeats;
   logic          w_inXfer;
   logic          w_portReady;
   logic          w_beatFire;

   // Arbitration for the IDLE cycle. Port 0 wins unless port 1 is waiting
   // and port 0 has already used up its run of consecutive grants.
   // Beat count is ceil(len/8); bits above bit 31 of len+7 cannot reach the
   // 29-bit result, so a 32-bit sum gives the same value as a wider one.
   always_comb begin
      w_consecFull = (r_consec == MAXC);
      w_win0       = i_req0 && !(i_req1 && w_consecFull);
      w_win1       = !w_win0 && i_req1;
      w_anyWin     = w_win0 || w_win1;
      w_selAddr    = w_win1 ? i_addr1 : i_addr0;
      w_selLen     = w_win1 ? i_len1  : i_len0;
      w_selBeats   = 29'((w_selLen + 32'd7) >> 3);
   end

   // Beat handshake towards memory only exists while a burst is in XFER;
   // memory beats arriving at any other time are neither routed nor counted.
   always_comb begin
      w_inXfer    = (r_state == S_XFER);
      w_portReady = r_grant ? i_ready1 : i_ready0;
      w_beatFire  = w_inXfer && w_portReady && i_mvalid;
   end

   // Main control: grant in IDLE, hold the request in ISSUE until memory
   // takes it, then count accepted beats in XFER. A zero-length grant skips
   // ISSUE and spends a single cycle in XFER with a zero beat count so the
   // port still sees o_busy for one cycle. Leaving XFER always lands in IDLE,
   // which guarantees at least one idle cycle between bursts.
   always_ff @(posedge sys_clock or negedge async_reset) begin
      if (!async_reset) begin
         r_state  <= S_IDLE;
         r_maddr  <= '0;
         r_mlen   <= '0;
         r_mreq   <= 1'b0;
         r_grant  <= 1'b0;
         r_beats  <= '0;
         r_consec <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_anyWin) begin
                  r_maddr <= w_selAddr;
                  r_mlen  <= w_selLen;
                  r_grant <= w_win1;
                  r_beats <= w_selBeats;
                  if (w_win1 || !i_req1) begin
                     r_consec <= '0;
                  end else if (!w_consecFull) begin
                     r_consec <= r_consec + CW'(1);
                  end
                  if (w_selLen == 32'd0) begin
                     r_state <= S_XFER;
                  end else begin
                     r_mreq  <= 1'b1;
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (i_mbusy) begin
                  r_mreq  <= 1'b0;
                  r_state <= S_XFER;
               end
            end
            S_XFER: begin
               if (r_beats == 29'd0) begin
                  r_state <= S_IDLE;
               end else if (w_beatFire) begin
                  r_beats <= r_beats - 29'd1;
                  if (r_beats == 29'd1) begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_mreq  <= 1'b0;
            end
         endcase
      end
   end

   // Output decode from registered state. Data is presented to both ports
   // during XFER; only the granted port gets valid. Everything is zero
   // outside XFER so reset clears every output immediately.
   always_comb begin
      o_maddr  = r_maddr;
      o_mlen   = r_mlen;
      o_mreq   = r_mreq;
      o_grant  = r_grant;
      o_busy0  = w_inXfer && !r_grant;
      o_busy1  = w_inXfer && r_grant;
      o_mready = w_inXfer && w_portReady;
      o_valid0 = w_inXfer && !r_grant && i_mvalid;
      o_valid1 = w_inXfer && r_grant && i_mvalid;
      o_data0  = w_inXfer ? i_mdata : 64'd0;
      o_data1  = w_inXfer ? i_mdata : 64'd0;
   end

endmodule

// File: tb/tb_gmem_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gmem_rd_arbiter
//
// Purpose:
//    Self-checking bench for gmem_rd_arbiter. A transaction-level model of
//    the arbiter predicts every output each cycle; directed scenarios add
//    hand-computed expectations on beat counts, grant order, stall and reset.
// ---------------------------------------------------------------------------
module tb_gmem_rd_arbiter;

   localparam int MAXC = 4;

   logic        sys_clock = 1'b0;
   logic        async_reset = 1'b1;
   logic        i_req0 = 1'b0;
   logic        i_req1 = 1'b0;
   logic [31:0] i_addr0 = '0;
   logic [31:0] i_addr1 = '0;
   logic [31:0] i_len0 = '0;
   logic [31:0] i_len1 = '0;
   logic        i_ready0 = 1'b1;
   logic        i_ready1 = 1'b1;
   logic        i_mbusy = 1'b0;
   logic [63:0] i_mdata = 64'hA5A5_0000_0000_0000;
   logic        i_mvalid = 1'b0;
   logic        o_busy0, o_busy1, o_valid0, o_valid1, o_mreq, o_mready, o_grant;
   logic [63:0] o_data0, o_data1;
   logic [31:0] o_maddr, o_mlen;

   int checks = 0;
   int errors = 0;

   gmem_rd_arbiter #(.MAX_CONSEC(MAXC)) dut (
      .sys_clock(sys_clock), .async_reset(async_reset),
      .i_req0(i_req0), .i_req1(i_req1),
      .i_addr0(i_addr0), .i_addr1(i_addr1),
      .i_len0(i_len0), .i_len1(i_len1),
      .o_busy0(o_busy0), .o_busy1(o_busy1),
      .o_data0(o_data0), .o_data1(o_data1),
      .o_valid0(o_valid0), .o_valid1(o_valid1),
      .i_ready0(i_ready0), .i_ready1(i_ready1),
      .o_maddr(o_maddr), .o_mlen(o_mlen), .o_mreq(o_mreq),
      .i_mbusy(i_mbusy), .i_mdata(i_mdata), .i_mvalid(i_mvalid),
      .o_mready(o_mready), .o_grant(o_grant)
   );

   // 10 time-unit clock.
   always #5 sys_clock = ~sys_clock;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a burst is either being requested, being transferred
   // or absent. It tracks remaining beats, who owns the burst and how many
   // port-0 grants in a row port 1 has had to wait through.
   bit          mdlIssuing = 0;
   bit          mdlXfer = 0;
   int          mdlPort = 0;
   logic [31:0] mdlAddr = '0;
   logic [31:0] mdlLen = '0;
   longint      mdlBeatsLeft = 0;
   int          mdlConsec = 0;
   int          mdlBurstBeats = 0;
   int          mdlBeatLog[$];
   int          mdlGrantLog[$];

   always @(posedge sys_clock or negedge async_reset) begin : modelProc
      int winner;
      if (!async_reset) begin
         mdlIssuing = 0; mdlXfer = 0; mdlPort = 0;
         mdlAddr = '0; mdlLen = '0; mdlBeatsLeft = 0; mdlConsec = 0;
      end else if (mdlXfer) begin
         if (mdlBeatsLeft == 0) begin
            mdlXfer = 0;
            mdlBeatLog.push_back(mdlBurstBeats);
         end else if (i_mvalid && ((mdlPort == 1) ? i_ready1 : i_ready0)) begin
            mdlBeatsLeft--;
            mdlBurstBeats++;
            if (mdlBeatsLeft == 0) begin
               mdlXfer = 0;
               mdlBeatLog.push_back(mdlBurstBeats);
            end
         end
      end else if (mdlIssuing) begin
         if (i_mbusy) begin
            mdlIssuing = 0;
            mdlXfer = 1;
         end
      end else begin
         winner = -1;
         if (i_req0 && !(i_req1 && mdlConsec == MAXC)) winner = 0;
         else if (i_req1) winner = 1;
         if (winner >= 0) begin
            mdlPort = winner;
            mdlAddr = (winner == 1) ? i_addr1 : i_addr0;
            mdlLen  = (winner == 1) ? i_len1 : i_len0;
            mdlBeatsLeft = ((longint'(mdlLen) + 7) / 8) % (longint'(1) << 29);
            mdlBurstBeats = 0;
            mdlGrantLog.push_back(winner);
            if (winner == 1 || !i_req1) mdlConsec = 0;
            else if (mdlConsec < MAXC) mdlConsec++;
            if (mdlLen == 0) mdlXfer = 1;
            else mdlIssuing = 1;
         end
      end
   end

   // Compare process: every output against the model on every falling edge.
   always @(negedge sys_clock) begin : compareProc
      bit expReady;
      expReady = mdlXfer && ((mdlPort == 1) ? i_ready1 : i_ready0);
      checkOutput("mreq", o_mreq, mdlIssuing);
      checkOutput("maddr", o_maddr, mdlAddr);
      checkOutput("mlen", o_mlen, mdlLen);
      checkOutput("grant", o_grant, mdlPort);
      checkOutput("busy0", o_busy0, mdlXfer && mdlPort == 0);
      checkOutput("busy1", o_busy1, mdlXfer && mdlPort == 1);
      checkOutput("mready", o_mready, expReady);
      checkOutput("valid0", o_valid0, mdlXfer && mdlPort == 0 && i_mvalid);
      checkOutput("valid1", o_valid1, mdlXfer && mdlPort == 1 && i_mvalid);
      checkOutput("data0", o_data0, mdlXfer ? i_mdata : 64'd0);
      checkOutput("data1", o_data1, mdlXfer ? i_mdata : 64'd0);
   end

   // Observation counters taken from the DUT outputs for the literal checks.
   int  dutBeats0 = 0;
   int  dutBeats1 = 0;
   int  busyCycles0 = 0;
   int  mreqCycles = 0;
   bit  prevBusy = 0;
   int  dutGrants[$];

   always @(negedge sys_clock) begin
      if (o_valid0 && o_mready) dutBeats0++;
      if (o_valid1 && o_mready) dutBeats1++;
      if (o_busy0) busyCycles0++;
      if (o_mreq) mreqCycles++;
      if ((o_busy0 || o_busy1) && !prevBusy) dutGrants.push_back(o_busy1 ? 1 : 0);
      prevBusy = o_busy0 || o_busy1;
   end

   // Memory responder: accepts a request three cycles after it appears,
   // streams beats with a gap every seventh cycle (also outside bursts),
   // and advances the data word after each accepted beat.
   initial begin
      int cyc = 0;
      int delay = 0;
      bit acc;
      forever begin
         @(negedge sys_clock);
         acc = i_mvalid && o_mready;
         @(posedge sys_clock);
         #2;
         cyc++;
         if (acc) i_mdata = i_mdata + 64'h0000_0001_0000_0003;
         if (o_mreq) begin
            delay++;
            i_mbusy = (delay >= 3);
         end else begin
            delay = 0;
            i_mbusy = 1'b0;
         end
         i_mvalid = (cyc % 7) != 3;
      end
   end

   task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: timed out, expected event did not occur at %0t", name, $time);
   endtask

   task automatic waitBusy(input int port, input int limit);
      int n;
      for (n = 0; n < limit; n++) begin
         @(negedge sys_clock); #1;
         if ((port == 0 && o_busy0) || (port == 1 && o_busy1)) break;
      end
      if (n == limit) timeoutFail(port == 0 ? "wait_busy0" : "wait_busy1");
   endtask

   task automatic waitIdle(input int limit);
      int n;
      for (n = 0; n < limit; n++) begin
         @(negedge sys_clock); #1;
         if (!o_busy0 && !o_busy1 && !o_mreq) break;
      end
      if (n == limit) timeoutFail("wait_idle");
   endtask

   task automatic waitBeats0(input int beats, input int limit);
      int n;
      for (n = 0; n < limit; n++) begin
         @(negedge sys_clock); #1;
         if (dutBeats0 >= beats) break;
      end
      if (n == limit) timeoutFail("wait_beats0");
   endtask

   // Raise one port's request, keep it until its busy shows, then drop it.
   task automatic applyStimulus(input int port, input logic [31:0] addr, input logic [31:0] len);
      @(posedge sys_clock); #1;
      if (port == 0) begin i_req0 = 1'b1; i_addr0 = addr; i_len0 = len; end
      else begin i_req1 = 1'b1; i_addr1 = addr; i_len1 = len; end
      waitBusy(port, 60);
      @(posedge sys_clock); #1;
      if (port == 0) i_req0 = 1'b0;
      else i_req1 = 1'b0;
   endtask

   int expGrants[6] = '{0, 0, 0, 0, 1, 0};

   initial begin
      int base;
      #1 async_reset = 1'b0;
      repeat (3) @(posedge sys_clock);
      #1;
      $display("[TB] reset state");
      checkOutput("rst_mreq", o_mreq, 0);
      checkOutput("rst_grant", o_grant, 0);
      checkOutput("rst_maddr", o_maddr, 0);

      // Long port-0 burst straight after reset release.
      $display("[TB] port 0 burst of 2400 bytes");
      async_reset = 1'b1;
      i_req0 = 1'b1; i_addr0 = 32'h1000_0000; i_len0 = 32'd2400;
      waitBusy(0, 60);
      @(posedge sys_clock); #1;
      i_req0 = 1'b0;
      waitIdle(1000);
      checkOutput("long_beats_dut", dutBeats0, 300);
      checkOutput("long_beats_model", mdlBeatLog[$], 300);
      checkOutput("long_maddr", o_maddr, 32'h1000_0000);
      checkOutput("long_mlen", o_mlen, 32'd2400);

      // Simultaneous requests: port 0 first, port 1 in the following IDLE.
      $display("[TB] simultaneous requests");
      base = dutGrants.size();
      @(posedge sys_clock); #1;
      i_req0 = 1'b1; i_addr0 = 32'h0000_2000; i_len0 = 32'd64;
      i_req1 = 1'b1; i_addr1 = 32'h0000_8000; i_len1 = 32'd40;
      waitBusy(0, 60);
      @(posedge sys_clock); #1;
      i_req0 = 1'b0;
      waitBusy(1, 100);
      @(posedge sys_clock); #1;
      i_req1 = 1'b0;
      waitIdle(200);
      checkOutput("simul_first", dutGrants[base], 0);
      checkOutput("simul_second", dutGrants[base + 1], 1);
      checkOutput("simul_addr1", o_maddr, 32'h0000_8000);

      // Fairness: port 0 continuous, port 1 pending.
      $display("[TB] consecutive grant limit");
      base = dutGrants.size();
      @(posedge sys_clock); #1;
      i_req0 = 1'b1; i_addr0 = 32'h0000_3000; i_len0 = 32'd16;
      i_req1 = 1'b1; i_addr1 = 32'h0000_9000; i_len1 = 32'd8;
      waitBusy(1, 400);
      @(posedge sys_clock); #1;
      i_req1 = 1'b0;
      for (int n = 0; n < 200 && dutGrants.size() < base + 6; n++) begin
         @(negedge sys_clock); #1;
      end
      @(posedge sys_clock); #1;
      i_req0 = 1'b0;
      waitIdle(200);
      for (int k = 0; k < 6; k++) begin
         checkOutput($sformatf("fair_dut_%0d", k), dutGrants[base + k], expGrants[k]);
         checkOutput($sformatf("fair_model_%0d", k), mdlGrantLog[mdlGrantLog.size() - 6 + k], expGrants[k]);
      end

      // Short burst: 20 bytes is three beats; zero length is one busy cycle.
      $display("[TB] short and zero-length bursts");
      dutBeats1 = 0;
      applyStimulus(1, 32'h0000_A000, 32'd20);
      waitIdle(100);
      checkOutput("len20_beats", dutBeats1, 3);
      checkOutput("len20_model", mdlBeatLog[$], 3);
      repeat (2) @(posedge sys_clock);
      #1;
      busyCycles0 = 0;
      mreqCycles = 0;
      applyStimulus(0, 32'h0000_B000, 32'd0);
      waitIdle(50);
      repeat (3) @(posedge sys_clock);
      #1;
      checkOutput("len0_busy", busyCycles0, 1);
      checkOutput("len0_mreq", mreqCycles, 0);

      // Port-0 stall for five cycles in the middle of a ten-beat burst.
      $display("[TB] ready stall");
      dutBeats0 = 0;
      applyStimulus(0, 32'h0000_C000, 32'd80);
      waitBeats0(4, 100);
      @(posedge sys_clock); #1;
      i_ready0 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge sys_clock); #1;
         checkOutput("stall_mready", o_mready, 0);
         checkOutput("stall_beats", dutBeats0, 4);
      end
      @(posedge sys_clock); #1;
      i_ready0 = 1'b1;
      waitIdle(100);
      checkOutput("stall_total", dutBeats0, 10);

      // Reset in the middle of a long burst, then a fresh burst.
      $display("[TB] reset mid-burst");
      dutBeats0 = 0;
      applyStimulus(0, 32'h1000_0000, 32'd2400);
      waitBeats0(100, 400);
      async_reset = 1'b0;
      #1;
      checkOutput("arst_mreq", o_mreq, 0);
      checkOutput("arst_busy0", o_busy0, 0);
      checkOutput("arst_valid0", o_valid0, 0);
      checkOutput("arst_mready", o_mready, 0);
      checkOutput("arst_maddr", o_maddr, 0);
      checkOutput("arst_mlen", o_mlen, 0);
      checkOutput("arst_data0", o_data0, 0);
      repeat (2) @(posedge sys_clock);
      #1;
      async_reset = 1'b1;
      dutBeats1 = 0;
      applyStimulus(1, 32'h0000_4000, 32'd24);
      waitIdle(100);
      checkOutput("post_rst_beats1", dutBeats1, 3);
      checkOutput("post_rst_beats0", dutBeats0, 100);
      checkOutput("post_rst_maddr", o_maddr, 32'h0000_4000);
      checkOutput("post_rst_grant", o_grant, 1);

      repeat (3) @(posedge sys_clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gmem_rd_arbiter.md
GMEM_RD_ARBITER -- requirements
Module: gmem_rd_arbiter

Interface
REQ-001 Parameter MAX_CONSEC, default 4: max consecutive port-0 grants while port 1 is pending.
REQ-002 sys_clock  in  1  system clock; all logic on rising edge.
REQ-003 async_reset  in  1  reset, asynchronous, active-low.
REQ-004 i_req0 / i_req1  in  1  level request from port 0 (video, high priority) / port 1 (general); held until o_busyN seen.
REQ-005 i_addr0 / i_addr1  in  32  byte start address of requested burst.
REQ-006 i_len0 / i_len1  in  32  burst length in bytes.
REQ-007 o_busy0 / o_busy1  out  1  port's transfer accepted and in progress.
REQ-008 o_data0 / o_data1  out  64  read data to port.
REQ-009 o_valid0 / o_valid1  out  1  read beat valid to port.
REQ-010 i_ready0 / i_ready1  in  1  port accepts beat.
REQ-011 o_maddr  out  32  shared memory read address (registered).
REQ-012 o_mlen  out  32  shared memory read length in bytes (registered).
REQ-013 o_mreq  out  1  shared memory request (registered).
REQ-014 i_mbusy  in  1  memory accepted request / burst in progress.
REQ-015 i_mdata  in  64  memory read data.
REQ-016 i_mvalid  in  1  memory read beat valid.
REQ-017 o_mready  out  1  beat accept to memory.
REQ-018 o_grant  out  1  index of currently/last granted port.

Function
REQ-019 States IDLE, ISSUE, XFER; one transfer outstanding at a time.
REQ-020 IDLE: port 0 wins if i_req0, unless i_req1 and consec count = MAX_CONSEC, then port 1 wins; else port 1 if i_req1; else stay.
REQ-021 On grant: latch addr/len into o_maddr/o_mlen, o_grant <= port, beats <= ceil(len/8) (i.e. (len+7)>>3, 29-bit), o_mreq <= 1, go ISSUE.
REQ-022 Consec count: +1 (saturating at MAX_CONSEC) on port-0 grant while i_req1 high; cleared on port-1 grant or port-0 grant with i_req1 low.
REQ-023 Grant with len = 0: no o_mreq; o_busyN high one cycle; return IDLE.
REQ-024 ISSUE: hold o_mreq=1 until i_mbusy sampled high; then o_mreq <= 0, go XFER.
REQ-025 o_busyN = 1 exactly while in XFER and o_grant = N (registered state decode).
REQ-026 XFER: o_dataN = i_mdata for both ports; o_validN = i_mvalid & (o_grant = N); o_mready = i_ready of granted port; o_mready = 0 outside XFER.
REQ-027 Beat counted on i_mvalid & o_mready; beat counter decrements; on final beat go IDLE next cycle.
REQ-028 i_mvalid outside XFER ignored, not routed, not counted.
REQ-029 Next grant evaluated in the IDLE cycle after XFER; minimum 1 idle cycle between bursts.
REQ-030 Requests deasserted during ISSUE/XFER do not abort the transfer.
REQ-031 Address/length arithmetic unsigned, no range checks; o_maddr passed unmodified.

Reset
REQ-032 Asynchronous, active-low, immediate: state IDLE, o_mreq 0, o_maddr 0, o_mlen 0, o_grant 0, beat and consec counters 0, all o_busyN/o_validN/o_mready 0.
REQ-033 Reset mid-transfer abandons the burst; no beats routed until a new grant after release.
REQ-034 First grant possible on the first clock edge after deassertion.

Verification
REQ-035 Port 0 only, addr 0x1000_0000, len 2400 -> o_maddr=0x10000000, o_mlen=2400, o_mreq held until i_mbusy, 300 beats on o_valid0, o_busy0 drops after beat 300.
REQ-036 i_req0 and i_req1 rise same cycle -> o_grant=0 first; port 1 granted in the IDLE after port-0 burst ends.
REQ-037 Port 0 requests continuously, port 1 pending, MAX_CONSEC=4 -> grants 0,0,0,0,1,0...
REQ-038 len=20 -> exactly 3 beats counted; len=0 -> o_busy one cycle, o_mreq never asserted.
REQ-039 i_ready0 low for 5 cycles mid-burst -> o_mready low, beat counter unchanged, no beat lost.
REQ-040 async_reset low at beat 100 of 300 -> all outputs 0 immediately; new request after release starts a fresh burst.
